// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// an elaboration-time ceiling-log2 helper.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   localparam logic [1:0] STATE_IDLE    = 2'd0;
   localparam logic [1:0] STATE_ISSUE   = 2'd1;
   localparam logic [1:0] STATE_CAPTURE = 2'd2;
   localparam logic [1:0] STATE_RESP    = 2'd3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((32'sd1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side and memory-side bus of the data-memory arbiter. The arbiter
// uses the slave view; cores plus memory (or a bench) use the master view.
interface dmem_arbiter_if #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 12,
   parameter int ADDR_W    = 12
);
   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES-1:0]        core_wren;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES*DATA_W-1:0] core_data;
   logic [NUM_CORES-1:0]        core_ack;
   logic [DATA_W-1:0]           core_rdata;
   logic                        busy;
   logic                        mem_wren;
   logic [ADDR_W-1:0]           mem_address;
   logic [DATA_W-1:0]           mem_data;
   logic [DATA_W-1:0]           mem_q;

   modport slave (
      input  core_req, core_wren, core_addr, core_data, mem_q,
      output core_ack, core_rdata, busy, mem_wren, mem_address, mem_data
   );

   modport master (
      output core_req, core_wren, core_addr, core_data, mem_q,
      input  core_ack, core_rdata, busy, mem_wren, mem_address, mem_data
   );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping modulo NUM_CORES.
module dmem_arbiter_rr_pick #(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic                 valid,
   output logic [IDX_W-1:0]     idx
);

   logic [IDX_W:0]   sum_s;
   logic [IDX_W-1:0] cand_s;

   // Scan from the farthest offset back toward ptr so the nearest requester wins.
   always_comb begin
      valid  = |req;
      idx    = {IDX_W{1'b0}};
      sum_s  = {(IDX_W+1){1'b0}};
      cand_s = {IDX_W{1'b0}};
      for (int off = NUM_CORES - 1; off >= 0; off--) begin
         sum_s = {1'b0, ptr} + (IDX_W+1)'(off);
         if (sum_s >= (IDX_W+1)'(NUM_CORES)) begin
            cand_s = IDX_W'(sum_s - (IDX_W+1)'(NUM_CORES));
         end else begin
            cand_s = sum_s[IDX_W-1:0];
         end
         idx = req[cand_s] ? cand_s : idx;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one registered-read data memory among
// NUM_CORES cores; one access per IDLE/ISSUE/CAPTURE/RESP pass.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 12,
   parameter int ADDR_W    = 12
) (
   input  logic          clock,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam int IDX_W = clog2(NUM_CORES);

   state_e               state_r, state_nxt_s;
   logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
   logic [IDX_W-1:0]     idx_r, idx_nxt_s;
   logic [IDX_W-1:0]     pick_idx_s;
   logic                 pick_valid_s;
   logic                 mem_wren_r, mem_wren_nxt_s;
   logic [ADDR_W-1:0]    mem_address_r, mem_address_nxt_s;
   logic [DATA_W-1:0]    mem_data_r, mem_data_nxt_s;
   logic [DATA_W-1:0]    core_rdata_r, core_rdata_nxt_s;
   logic [NUM_CORES-1:0] core_ack_r, core_ack_nxt_s;
   logic                 busy_r, busy_nxt_s;
   logic [ADDR_W-1:0]    addr_arr_s [NUM_CORES];
   logic [DATA_W-1:0]    data_arr_s [NUM_CORES];

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_split
      assign addr_arr_s[g] = bus.core_addr[g*ADDR_W +: ADDR_W];
      assign data_arr_s[g] = bus.core_data[g*DATA_W +: DATA_W];
   end

   dmem_arbiter_rr_pick #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_rr_pick (
      .req   (bus.core_req),
      .ptr   (rr_ptr_r),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   // Next-state and next-output decode; mem_wren is only ever high in ISSUE.
   always_comb begin
      state_nxt_s       = state_r;
      rr_ptr_nxt_s      = rr_ptr_r;
      idx_nxt_s         = idx_r;
      mem_wren_nxt_s    = 1'b0;
      mem_address_nxt_s = mem_address_r;
      mem_data_nxt_s    = mem_data_r;
      core_rdata_nxt_s  = core_rdata_r;
      core_ack_nxt_s    = {NUM_CORES{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s       = ST_ISSUE;
               idx_nxt_s         = pick_idx_s;
               mem_wren_nxt_s    = bus.core_wren[pick_idx_s];
               mem_address_nxt_s = addr_arr_s[pick_idx_s];
               mem_data_nxt_s    = data_arr_s[pick_idx_s];
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nxt_s = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_nxt_s      = ST_RESP;
            core_rdata_nxt_s = bus.mem_q;
            core_ack_nxt_s   = {{(NUM_CORES-1){1'b0}}, 1'b1} << idx_r;
            if (idx_r == IDX_W'(NUM_CORES - 1)) begin
               rr_ptr_nxt_s = {IDX_W{1'b0}};
            end else begin
               rr_ptr_nxt_s = idx_r + IDX_W'(1);
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // State and output registers; reset also kills an in-flight write strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         rr_ptr_r      <= {IDX_W{1'b0}};
         idx_r         <= {IDX_W{1'b0}};
         mem_wren_r    <= 1'b0;
         mem_address_r <= {ADDR_W{1'b0}};
         mem_data_r    <= {DATA_W{1'b0}};
         core_rdata_r  <= {DATA_W{1'b0}};
         core_ack_r    <= {NUM_CORES{1'b0}};
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         rr_ptr_r      <= rr_ptr_nxt_s;
         idx_r         <= idx_nxt_s;
         mem_wren_r    <= mem_wren_nxt_s;
         mem_address_r <= mem_address_nxt_s;
         mem_data_r    <= mem_data_nxt_s;
         core_rdata_r  <= core_rdata_nxt_s;
         core_ack_r    <= core_ack_nxt_s;
         busy_r        <= busy_nxt_s;
      end
   end

   assign bus.core_ack    = core_ack_r;
   assign bus.core_rdata  = core_rdata_r;
   assign bus.busy        = busy_r;
   assign bus.mem_wren    = mem_wren_r;
   assign bus.mem_address = mem_address_r;
   assign bus.mem_data    = mem_data_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;

   localparam int NUM_CORES = 4;
   localparam int DATA_W    = 12;
   localparam int ADDR_W    = 12;

   logic              clock = 1'b0;
   logic              reset;
   logic              bd_we;
   logic [ADDR_W-1:0] bd_addr;
   logic [DATA_W-1:0] bd_data;
   logic [DATA_W-1:0] mem_model [4096];
   int                n_cmp = 0;
   int                n_bad = 0;

   dmem_arbiter_if #(.NUM_CORES(NUM_CORES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dmem_arbiter #(.NUM_CORES(NUM_CORES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Single-port memory: q registered, read-before-write, plus a preload port.
   always @(posedge clock) begin
      if (bd_we) begin
         mem_model[bd_addr] <= bd_data;
      end else if (bus.mem_wren) begin
         mem_model[bus.mem_address] <= bus.mem_data;
      end
      bus.mem_q <= mem_model[bus.mem_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      tick();
      bd_we   = 1'b0;
   endtask

   task automatic fields(input int c, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      bus.core_wren[c]                  = wr;
      bus.core_addr[c*ADDR_W +: ADDR_W] = a;
      bus.core_data[c*DATA_W +: DATA_W] = d;
   endtask

   // One access starting from IDLE: ISSUE, CAPTURE, RESP (ack), back to IDLE.
   task automatic access(input string tag, input logic [3:0] exp_ack, input logic exp_wr,
                         input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] exp_data,
                         input logic [DATA_W-1:0] exp_rdata, input logic [3:0] drop,
                         input logic [3:0] late);
      tick();
      check({tag, "_issue_busy"}, 32'(bus.busy), 32'h1);
      check({tag, "_issue_wren"}, 32'(bus.mem_wren), 32'(exp_wr));
      check({tag, "_issue_addr"}, 32'(bus.mem_address), 32'(exp_addr));
      check({tag, "_issue_data"}, 32'(bus.mem_data), 32'(exp_data));
      check({tag, "_issue_ack"}, 32'(bus.core_ack), 32'h0);
      bus.core_req = bus.core_req | late;
      tick();
      check({tag, "_capt_wren"}, 32'(bus.mem_wren), 32'h0);
      check({tag, "_capt_ack"}, 32'(bus.core_ack), 32'h0);
      tick();
      check({tag, "_resp_ack"}, 32'(bus.core_ack), 32'(exp_ack));
      check({tag, "_resp_rdata"}, 32'(bus.core_rdata), 32'(exp_rdata));
      check({tag, "_resp_busy"}, 32'(bus.busy), 32'h1);
      bus.core_req = bus.core_req & ~drop;
      tick();
      check({tag, "_idle_ack"}, 32'(bus.core_ack), 32'h0);
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
      check({tag, "_idle_rdata"}, 32'(bus.core_rdata), 32'(exp_rdata));
   endtask

   initial begin
      reset         = 1'b1;
      bd_we         = 1'b0;
      bd_addr       = 12'h000;
      bd_data       = 12'h000;
      bus.core_req  = 4'b0000;
      bus.core_wren = 4'b0000;
      bus.core_addr = 48'h0;
      bus.core_data = 48'h0;

      bd_write(12'h005, 12'h000);
      bd_write(12'h007, 12'h000);
      bd_write(12'h010, 12'h100);
      bd_write(12'h011, 12'h101);
      bd_write(12'h012, 12'h102);
      bd_write(12'h013, 12'h103);
      bd_write(12'h020, 12'h055);
      check("rst_ack", 32'(bus.core_ack), 32'h0);
      check("rst_rdata", 32'(bus.core_rdata), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_wren", 32'(bus.mem_wren), 32'h0);
      check("rst_addr", 32'(bus.mem_address), 32'h0);
      check("rst_data", 32'(bus.mem_data), 32'h0);
      reset = 1'b0;
      tick();

      // Core0 write then read back.
      fields(0, 1'b1, 12'h005, 12'hABC);
      bus.core_req = 4'b0001;
      access("t1_wr", 4'b0001, 1'b1, 12'h005, 12'hABC, 12'h000, 4'b0001, 4'b0000);
      fields(0, 1'b0, 12'h005, 12'h000);
      bus.core_req = 4'b0001;
      access("t1_rd", 4'b0001, 1'b0, 12'h005, 12'h000, 12'hABC, 4'b0001, 4'b0000);

      // Reset returns pointer to 0 and clears rdata; then all four request at once.
      reset = 1'b1;
      tick();
      check("t2_rst_rdata", 32'(bus.core_rdata), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fields(i, 1'b0, 12'(32'h010 + i), 12'h000);
      end
      bus.core_req = 4'b1111;
      access("t2_c0", 4'b0001, 1'b0, 12'h010, 12'h000, 12'h100, 4'b0001, 4'b0000);
      access("t2_c1", 4'b0010, 1'b0, 12'h011, 12'h000, 12'h101, 4'b0010, 4'b0000);
      access("t2_c2", 4'b0100, 1'b0, 12'h012, 12'h000, 12'h102, 4'b0100, 4'b0000);
      access("t2_c3", 4'b1000, 1'b0, 12'h013, 12'h000, 12'h103, 4'b1000, 4'b0000);

      // Core2 holds its request; core1 arrives during core2's first access.
      fields(2, 1'b0, 12'h012, 12'h000);
      fields(1, 1'b0, 12'h011, 12'h000);
      bus.core_req = 4'b0100;
      access("t3_g0", 4'b0100, 1'b0, 12'h012, 12'h000, 12'h102, 4'b0000, 4'b0010);
      access("t3_g1", 4'b0010, 1'b0, 12'h011, 12'h000, 12'h101, 4'b0010, 4'b0000);
      access("t3_g2", 4'b0100, 1'b0, 12'h012, 12'h000, 12'h102, 4'b0000, 4'b0000);
      access("t3_g3", 4'b0100, 1'b0, 12'h012, 12'h000, 12'h102, 4'b0100, 4'b0000);

      // Read-before-write on core3, then read the new value.
      fields(3, 1'b1, 12'h020, 12'h7FF);
      bus.core_req = 4'b1000;
      access("t4_wr", 4'b1000, 1'b1, 12'h020, 12'h7FF, 12'h055, 4'b1000, 4'b0000);
      fields(3, 1'b0, 12'h020, 12'h000);
      bus.core_req = 4'b1000;
      access("t4_rd", 4'b1000, 1'b0, 12'h020, 12'h000, 12'h7FF, 4'b1000, 4'b0000);

      // Core3 was last winner, so the pointer wrapped: core0 beats core3.
      fields(0, 1'b0, 12'h005, 12'h000);
      bus.core_req = 4'b1001;
      access("t5_c0", 4'b0001, 1'b0, 12'h005, 12'h000, 12'hABC, 4'b0001, 4'b0000);
      access("t5_c3", 4'b1000, 1'b0, 12'h020, 12'h000, 12'h7FF, 4'b1000, 4'b0000);

      // Move pointer to 1, then abort a core1 write with reset during ISSUE.
      fields(0, 1'b0, 12'h013, 12'h000);
      bus.core_req = 4'b0001;
      access("t6_pre", 4'b0001, 1'b0, 12'h013, 12'h000, 12'h103, 4'b0001, 4'b0000);
      fields(1, 1'b1, 12'h007, 12'h111);
      bus.core_req = 4'b0010;
      tick();
      check("t6_issue_wren", 32'(bus.mem_wren), 32'h1);
      check("t6_issue_addr", 32'(bus.mem_address), 32'h007);
      #3;
      reset = 1'b1;
      #1;
      check("t6_async_wren", 32'(bus.mem_wren), 32'h0);
      check("t6_async_busy", 32'(bus.busy), 32'h0);
      bus.core_req = 4'b0000;
      tick();
      reset = 1'b0;
      tick();
      check("t6_no_ack_a", 32'(bus.core_ack), 32'h0);
      tick();
      check("t6_no_ack_b", 32'(bus.core_ack), 32'h0);
      check("t6_busy", 32'(bus.busy), 32'h0);
      check("t6_mem7", 32'(mem_model[12'h007]), 32'h000);
      fields(0, 1'b0, 12'h007, 12'h000);
      fields(1, 1'b0, 12'h007, 12'h000);
      bus.core_req = 4'b0011;
      access("t6_ptr", 4'b0001, 1'b0, 12'h007, 12'h000, 12'h000, 4'b0011, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
